// File: rtl/jtframe_rom_dwnld_if.sv
// Bundle of ioctl byte-stream, SDRAM programming and status signals.
// master: download host / SDRAM side; slave: the download sequencer.
interface jtframe_rom_dwnld_if;
    logic        downloading;
    logic [21:0] ioctl_addr;
    logic [7:0]  ioctl_data;
    logic        ioctl_wr;
    logic [21:0] prog_addr;
    logic [7:0]  prog_data;
    logic [1:0]  prog_mask;
    logic        prog_we;
    logic        prog_ack;
    logic        prom_we;
    logic [11:0] prom_addr;
    logic [1:0]  region;
    logic        overrun;
    logic        dwnld_done;

    modport master (
        output downloading, ioctl_addr, ioctl_data, ioctl_wr, prog_ack,
        input  prog_addr, prog_data, prog_mask, prog_we,
        input  prom_we, prom_addr, region, overrun, dwnld_done
    );

    modport slave (
        input  downloading, ioctl_addr, ioctl_data, ioctl_wr, prog_ack,
        output prog_addr, prog_data, prog_mask, prog_we,
        output prom_we, prom_addr, region, overrun, dwnld_done
    );
endinterface

// File: rtl/jtframe_rom_dwnld.sv
// ROM download sequencer: remaps ioctl bytes to SDRAM words with lane masks,
// one-word buffer behind the ack handshake, sticky overrun, end-of-transfer pulse.
// Ports: clk_rom, rst (synchronous, active high), bus (jtframe_rom_dwnld_if.slave).
// Macro JTFRAME_DWNLD_PROM_EN diverts bytes at/above PROM_START to prom_we/prom_addr.
module jtframe_rom_dwnld #(
    parameter int          SWAB        = 0,
    parameter logic [21:0] REG1_START  = 22'h10000,
    parameter logic [21:0] REG2_START  = 22'h20000,
    parameter logic [21:0] REG3_START  = 22'h30000,
    parameter logic [21:0] REG1_OFFSET = 22'h10000,
    parameter logic [21:0] REG2_OFFSET = 22'h20000,
    parameter logic [21:0] REG3_OFFSET = 22'h30000,
    parameter logic [21:0] PROM_START  = 22'h3F000
) (
    input  logic                clk_rom,
    input  logic                rst,
    jtframe_rom_dwnld_if.slave  bus
);
`ifdef JTFRAME_DWNLD_PROM_EN
    localparam bit PROM_EN = 1'b1;
`else
    localparam bit PROM_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, REQ, GAP, FLUSH} state_t;

    typedef struct packed {
        logic [21:0] addr;
        logic [7:0]  data;
        logic [1:0]  mask;
    } word_t;

    localparam word_t WORD_RST = '{addr: 22'd0, data: 8'd0, mask: 2'b11};

    state_t      state, n_state;
    word_t       cur_q, n_cur, buf_q, n_buf, new_w;
    logic        we_q, n_we, buf_v, n_buf_v;
    logic [1:0]  region_q, n_region, k;
    logic        ovr_q, n_ovr, done_q, n_done, dl_q;
    logic        prom_we_q, n_prom_we;
    logic [11:0] prom_addr_q, n_prom_addr;
    logic [21:0] start, offset;
    logic [1:0]  lane;
    logic        is_prom, acc, retire, dl_fall, dl_rise;

    // Region decode and word address/lane for the incoming byte
    always_comb begin
        k      = 2'd0;
        start  = 22'd0;
        offset = 22'd0;
        if (bus.ioctl_addr >= REG1_START) begin
            k = 2'd1; start = REG1_START; offset = REG1_OFFSET;
        end
        if (bus.ioctl_addr >= REG2_START) begin
            k = 2'd2; start = REG2_START; offset = REG2_OFFSET;
        end
        if (bus.ioctl_addr >= REG3_START) begin
            k = 2'd3; start = REG3_START; offset = REG3_OFFSET;
        end
        lane       = bus.ioctl_addr[0] ? 2'b01 : 2'b10;
        new_w.addr = offset + ((bus.ioctl_addr - start) >> 1);
        new_w.data = bus.ioctl_data;
        new_w.mask = (SWAB != 0) ? ~lane : lane;
    end

    assign is_prom = PROM_EN && (bus.ioctl_addr >= PROM_START);
    assign acc     = bus.ioctl_wr & bus.downloading & ~is_prom;
    assign retire  = we_q & bus.prog_ack;
    assign dl_fall = dl_q & ~bus.downloading;
    assign dl_rise = ~dl_q & bus.downloading;

    always_comb begin
        n_state     = state;
        n_cur       = cur_q;
        n_we        = we_q;
        n_buf       = buf_q;
        n_buf_v     = buf_v;
        n_region    = region_q;
        n_ovr       = ovr_q & ~dl_rise;
        n_done      = 1'b0;
        n_prom_we   = PROM_EN & bus.ioctl_wr & bus.downloading & is_prom;
        n_prom_addr = prom_addr_q;
        if (n_prom_we)
            n_prom_addr = 12'(bus.ioctl_addr - PROM_START);
        unique case (state)
            IDLE: if (acc) begin
                n_cur    = new_w;
                n_we     = 1'b1;
                n_region = k;
                n_state  = REQ;
            end
            REQ: begin
                if (retire) begin
                    n_we    = 1'b0;
                    n_state = GAP;
                end
                if (acc) begin
                    if (buf_v) n_ovr = 1'b1;
                    else begin
                        n_buf    = new_w;
                        n_buf_v  = 1'b1;
                        n_region = k;
                    end
                end
            end
            GAP: begin
                if (buf_v) begin
                    n_cur   = buf_q;
                    n_we    = 1'b1;
                    n_buf_v = 1'b0;
                    n_state = REQ;
                    if (acc) n_ovr = 1'b1;
                end else if (acc) begin
                    // Empty buffer: the new byte issues straight after the gap
                    n_cur    = new_w;
                    n_we     = 1'b1;
                    n_region = k;
                    n_state  = REQ;
                end else begin
                    n_state = IDLE;
                end
            end
            FLUSH: begin
                if (retire) n_we = 1'b0;
                else if (!we_q && buf_v) begin
                    n_cur   = buf_q;
                    n_we    = 1'b1;
                    n_buf_v = 1'b0;
                end else if (!we_q) begin
                    n_state = IDLE;
                    n_done  = 1'b1;
                end
            end
        endcase
        if (dl_fall && state != FLUSH) begin
            if (we_q || buf_v) n_state = FLUSH;
            else n_done = 1'b1;
        end
    end

    always_ff @(posedge clk_rom) begin
        if (rst) begin
            state       <= IDLE;
            cur_q       <= WORD_RST;
            buf_q       <= WORD_RST;
            we_q        <= 1'b0;
            buf_v       <= 1'b0;
            region_q    <= 2'd0;
            ovr_q       <= 1'b0;
            done_q      <= 1'b0;
            dl_q        <= 1'b0;
            prom_we_q   <= 1'b0;
            prom_addr_q <= 12'd0;
        end else begin
            state       <= n_state;
            cur_q       <= n_cur;
            buf_q       <= n_buf;
            we_q        <= n_we;
            buf_v       <= n_buf_v;
            region_q    <= n_region;
            ovr_q       <= n_ovr;
            done_q      <= n_done;
            dl_q        <= bus.downloading;
            prom_we_q   <= n_prom_we;
            prom_addr_q <= n_prom_addr;
        end
    end

    assign bus.prog_addr  = cur_q.addr;
    assign bus.prog_data  = cur_q.data;
    assign bus.prog_mask  = cur_q.mask;
    assign bus.prog_we    = we_q;
    assign bus.prom_we    = prom_we_q;
    assign bus.prom_addr  = prom_addr_q;
    assign bus.region     = region_q;
    assign bus.overrun    = ovr_q;
    assign bus.dwnld_done = done_q;
endmodule

// File: tb/tb_jtframe_rom_dwnld.sv
// Directed + randomized bench for jtframe_rom_dwnld (SWAB=0 and SWAB=1 instances).
// Expected words come from a region-table reference model of the address map.
module tb_jtframe_rom_dwnld;
    logic clk_rom = 1'b0;
    logic rst;
    int   checks = 0;
    int   passed = 0;

    always #5 clk_rom = ~clk_rom;

    jtframe_rom_dwnld_if bus();
    jtframe_rom_dwnld_if bus_sw();

    assign bus_sw.downloading = bus.downloading;
    assign bus_sw.ioctl_addr  = bus.ioctl_addr;
    assign bus_sw.ioctl_data  = bus.ioctl_data;
    assign bus_sw.ioctl_wr    = bus.ioctl_wr;
    assign bus_sw.prog_ack    = bus.prog_ack;

    jtframe_rom_dwnld #(.SWAB(0)) dut (
        .clk_rom (clk_rom),
        .rst     (rst),
        .bus     (bus)
    );

    jtframe_rom_dwnld #(.SWAB(1)) dut_sw (
        .clk_rom (clk_rom),
        .rst     (rst),
        .bus     (bus_sw)
    );

`ifdef JTFRAME_DWNLD_PROM_EN
    localparam logic [21:0] AMAX = 22'h3EFFF;
`else
    localparam logic [21:0] AMAX = 22'h3FFFFF;
`endif

    localparam logic [21:0] ST [4] = '{22'h0, 22'h10000, 22'h20000, 22'h30000};
    localparam logic [21:0] OF [4] = '{22'h0, 22'h10000, 22'h20000, 22'h30000};

    function automatic int m_region(input logic [21:0] a);
        int r = 0;
        for (int i = 1; i < 4; i++)
            if (a >= ST[i]) r = i;
        return r;
    endfunction

    function automatic logic [21:0] m_addr(input logic [21:0] a);
        int r = m_region(a);
        logic [21:0] rel = a - ST[r];
        return OF[r] + rel / 2;
    endfunction

    function automatic logic [1:0] m_mask(input logic [21:0] a, input bit swab);
        logic [1:0] m = (a % 2 == 1) ? 2'b01 : 2'b10;
        return swab ? ~m : m;
    endfunction

    task automatic tick();
        @(posedge clk_rom);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic do_wr(input logic [21:0] a, input logic [7:0] d);
        bus.ioctl_addr = a;
        bus.ioctl_data = d;
        bus.ioctl_wr   = 1'b1;
        tick();
        bus.ioctl_wr   = 1'b0;
    endtask

    task automatic ack_once();
        bus.prog_ack = 1'b1;
        tick();
        bus.prog_ack = 1'b0;
    endtask

    task automatic chk_req(input string tag, input logic [21:0] a, input logic [7:0] d);
        chk({tag, ".we"},   32'(bus.prog_we),      32'd1);
        chk({tag, ".addr"}, 32'(bus.prog_addr),    32'(m_addr(a)));
        chk({tag, ".data"}, 32'(bus.prog_data),    32'(d));
        chk({tag, ".mask"}, 32'(bus.prog_mask),    32'(m_mask(a, 1'b0)));
        chk({tag, ".swab"}, 32'(bus_sw.prog_mask), 32'(m_mask(a, 1'b1)));
        chk({tag, ".rgn"},  32'(bus.region),       32'(m_region(a)));
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".we"},    32'(bus.prog_we),    32'd0);
        chk({tag, ".addr"},  32'(bus.prog_addr),  32'd0);
        chk({tag, ".data"},  32'(bus.prog_data),  32'd0);
        chk({tag, ".mask"},  32'(bus.prog_mask),  32'd3);
        chk({tag, ".pwe"},   32'(bus.prom_we),    32'd0);
        chk({tag, ".paddr"}, 32'(bus.prom_addr),  32'd0);
        chk({tag, ".rgn"},   32'(bus.region),     32'd0);
        chk({tag, ".ovr"},   32'(bus.overrun),    32'd0);
        chk({tag, ".done"},  32'(bus.dwnld_done), 32'd0);
    endtask

    initial begin
        logic [21:0] ra;
        logic [7:0]  rd;
        rst             = 1'b1;
        bus.downloading = 1'b0;
        bus.ioctl_addr  = '0;
        bus.ioctl_data  = '0;
        bus.ioctl_wr    = 1'b0;
        bus.prog_ack    = 1'b0;
        repeat (2) tick();
        chk_reset("rst");
        rst = 1'b0;
        tick();
        chk_reset("idle");
        bus.downloading = 1'b1;
        tick();

        // Region 0, odd byte, ack after 4 cycles
        do_wr(22'h00003, 8'hA5);
        chk_req("r0", 22'h00003, 8'hA5);
        chk("r0.addr_k", 32'(bus.prog_addr), 32'h1);
        chk("r0.mask_k", 32'(bus.prog_mask), 32'h1);
        repeat (3) tick();
        chk("r0.hold", 32'(bus.prog_we), 32'd1);
        chk("r0.hold_a", 32'(bus.prog_addr), 32'h1);
        ack_once();
        chk("r0.ackwe", 32'(bus.prog_we), 32'd0);
        tick();

        // Region 1, even byte
        do_wr(22'h10004, 8'h3C);
        chk_req("r1", 22'h10004, 8'h3C);
        chk("r1.addr_k", 32'(bus.prog_addr), 32'h10002);
        chk("r1.swab_k", 32'(bus_sw.prog_mask), 32'h1);
        ack_once();
        chk("r1.ackwe", 32'(bus.prog_we), 32'd0);
        tick();

        // Three back-to-back strobes: issue, buffer, drop
        do_wr(22'h20010, 8'h11);
        do_wr(22'h20011, 8'h22);
        do_wr(22'h20012, 8'h33);
        chk("bb.first", 32'(bus.prog_addr), 32'(m_addr(22'h20010)));
        chk("bb.ovr", 32'(bus.overrun), 32'd1);
        ack_once();
        chk("bb.gap", 32'(bus.prog_we), 32'd0);
        tick();
        chk_req("bb.second", 22'h20011, 8'h22);
        ack_once();
        repeat (2) tick();
        chk("bb.nothird", 32'(bus.prog_we), 32'd0);

        // Fall with nothing pending, ignored strobe, overrun clear on rise
        bus.downloading = 1'b0;
        tick();
        chk("fall.done", 32'(bus.dwnld_done), 32'd1);
        tick();
        chk("fall.once", 32'(bus.dwnld_done), 32'd0);
        do_wr(22'h00005, 8'h77);
        chk("off.ign", 32'(bus.prog_we), 32'd0);
        chk("off.ovr", 32'(bus.overrun), 32'd1);
        bus.downloading = 1'b1;
        tick();
        chk("rise.ovr", 32'(bus.overrun), 32'd0);

        // End of transfer with one pending and one buffered
        do_wr(22'h00100, 8'h44);
        do_wr(22'h00101, 8'h55);
        bus.downloading = 1'b0;
        tick();
        chk("fl.we", 32'(bus.prog_we), 32'd1);
        chk("fl.d0", 32'(bus.dwnld_done), 32'd0);
        ack_once();
        chk("fl.gap", 32'(bus.prog_we), 32'd0);
        tick();
        chk_req("fl.b", 22'h00101, 8'h55);
        chk("fl.d1", 32'(bus.dwnld_done), 32'd0);
        ack_once();
        chk("fl.d2", 32'(bus.dwnld_done), 32'd0);
        tick();
        chk("fl.done", 32'(bus.dwnld_done), 32'd1);
        tick();
        chk("fl.once", 32'(bus.dwnld_done), 32'd0);
        bus.downloading = 1'b1;
        tick();

        // PROM area
        do_wr(22'h3F010, 8'h0F);
`ifdef JTFRAME_DWNLD_PROM_EN
        chk("prom.we", 32'(bus.prom_we), 32'd1);
        chk("prom.addr", 32'(bus.prom_addr), 32'h010);
        chk("prom.nowe", 32'(bus.prog_we), 32'd0);
        tick();
        chk("prom.pulse", 32'(bus.prom_we), 32'd0);
`else
        chk_req("prom", 22'h3F010, 8'h0F);
        chk("prom.off", 32'(bus.prom_we), 32'd0);
        ack_once();
        tick();
`endif

        // Reset with request and buffer both full
        do_wr(22'h00200, 8'h66);
        do_wr(22'h00201, 8'h67);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset("mid");
        ack_once();
        chk("mid.ack", 32'(bus.prog_we), 32'd0);
        repeat (2) tick();
        chk("mid.noreq", 32'(bus.prog_we), 32'd0);

        // Randomized single writes against the region model
        for (int n = 0; n < 16; n++) begin
            ra = 22'($urandom_range(0, int'(AMAX)));
            rd = 8'($urandom);
            do_wr(ra, rd);
            chk_req($sformatf("rnd%0d", n), ra, rd);
            repeat ($urandom_range(0, 3)) tick();
            chk("rnd.hold", 32'(bus.prog_addr), 32'(m_addr(ra)));
            ack_once();
            chk("rnd.ackwe", 32'(bus.prog_we), 32'd0);
            tick();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
